// File: rtl/ft_cmd_rx.sv
// rtl/ft_cmd_rx.sv - FT245-style FIFO read engine and 5-byte command deframer
// Reads bytes over FT_RXF/FT_RD, validates sync/checksum, delivers commands via valid/ready.
module ft_cmd_rx #(
   parameter int         RD_LOW_CYCLES  = 4,
   parameter int         RD_HIGH_CYCLES = 4,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] SYNC_BYTE      = 8'h55
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ft_rxf_n,
   input  logic [7:0]  ft_d_in,
   output logic        ft_rd_n,
   input  logic        rd_en,
   output logic        rd_active,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_opcode,
   output logic [15:0] cmd_arg,
   output logic [7:0]  err_count
);

   localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOW_LAST  = CW'(RD_LOW_CYCLES - 1);
   localparam logic [CW-1:0] HIGH_LAST = CW'(RD_HIGH_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {B_IDLE, B_RD_LOW, B_RD_HIGH} bus_state_t;
   typedef enum logic [2:0] {P_SYNC, P_OPC, P_ARGH, P_ARGL, P_CSUM} prs_state_t;

   logic          rxf_meta_q, rxf_meta_d, rxf_sync_q, rxf_sync_d;
   bus_state_t    bus_state_q, bus_state_d;
   logic [CW-1:0] bus_cnt_q, bus_cnt_d;
   logic          capture;
   logic          ft_rd_n_q, ft_rd_n_d, rd_active_q, rd_active_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          strobe_q, strobe_d;
   prs_state_t    ps_q, ps_d;
   logic [7:0]    opc_q, opc_d, argh_q, argh_d, argl_q, argl_d;
   logic [TW-1:0] gap_q, gap_d;
   logic          timeout, err_inc;
   logic          cmd_valid_q, cmd_valid_d;
   logic [7:0]    cmd_opcode_q, cmd_opcode_d;
   logic [15:0]   cmd_arg_q, cmd_arg_d;
   logic [7:0]    err_q, err_d;

   // Bus FSM state register, including its registered outputs so ft_rd_n is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_state_q <= B_IDLE;
         bus_cnt_q   <= '0;
         ft_rd_n_q   <= 1'b1;
         rd_active_q <= 1'b0;
         rx_byte_q   <= 8'h00;
         strobe_q    <= 1'b0;
      end else begin
         bus_state_q <= bus_state_d;
         bus_cnt_q   <= bus_cnt_d;
         ft_rd_n_q   <= ft_rd_n_d;
         rd_active_q <= rd_active_d;
         rx_byte_q   <= rx_byte_d;
         strobe_q    <= strobe_d;
      end
   end

   always_comb begin
      bus_state_d = bus_state_q;
      bus_cnt_d   = bus_cnt_q;
      capture     = 1'b0;
      case (bus_state_q)
         B_IDLE: begin
            if (!rxf_sync_q && rd_en && !cmd_valid_q) begin
               bus_state_d = B_RD_LOW;
               bus_cnt_d   = '0;
            end
         end
         B_RD_LOW: begin
            if (bus_cnt_q == LOW_LAST) begin
               capture     = 1'b1;
               bus_state_d = B_RD_HIGH;
               bus_cnt_d   = '0;
            end else begin
               bus_cnt_d = bus_cnt_q + CW'(1);
            end
         end
         B_RD_HIGH: begin
            if (bus_cnt_q == HIGH_LAST) begin
               bus_state_d = B_IDLE;
               bus_cnt_d   = '0;
            end else begin
               bus_cnt_d = bus_cnt_q + CW'(1);
            end
         end
         default: begin
            bus_state_d = B_IDLE;
            bus_cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ft_rd_n_d   = (bus_state_d != B_RD_LOW);
      rd_active_d = (bus_state_d != B_IDLE);
      rx_byte_d   = capture ? ft_d_in : rx_byte_q;
      strobe_d    = capture;
   end

   always_comb begin
      rxf_meta_d = ft_rxf_n;
      rxf_sync_d = rxf_meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxf_meta_q   <= 1'b1;
         rxf_sync_q   <= 1'b1;
         ps_q         <= P_SYNC;
         opc_q        <= 8'h00;
         argh_q       <= 8'h00;
         argl_q       <= 8'h00;
         gap_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_opcode_q <= 8'h00;
         cmd_arg_q    <= 16'h0000;
         err_q        <= 8'h00;
      end else begin
         rxf_meta_q   <= rxf_meta_d;
         rxf_sync_q   <= rxf_sync_d;
         ps_q         <= ps_d;
         opc_q        <= opc_d;
         argh_q       <= argh_d;
         argl_q       <= argl_d;
         gap_q        <= gap_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_opcode_q <= cmd_opcode_d;
         cmd_arg_q    <= cmd_arg_d;
         err_q        <= err_d;
      end
   end

   // Gap timer is frozen during consumer stalls and bus sharing so neither can abort a frame
   always_comb begin
      gap_d   = gap_q;
      timeout = 1'b0;
      if (strobe_q || ps_q == P_SYNC) begin
         gap_d = '0;
      end else if (!cmd_valid_q && rd_en) begin
         if (gap_q == GAP_LAST) begin
            timeout = 1'b1;
            gap_d   = '0;
         end else begin
            gap_d = gap_q + TW'(1);
         end
      end
   end

   always_comb begin
      ps_d         = ps_q;
      opc_d        = opc_q;
      argh_d       = argh_q;
      argl_d       = argl_q;
      cmd_valid_d  = cmd_valid_q && !cmd_ready;
      cmd_opcode_d = cmd_opcode_q;
      cmd_arg_d    = cmd_arg_q;
      err_inc      = 1'b0;
      if (strobe_q) begin
         case (ps_q)
            P_SYNC: if (rx_byte_q == SYNC_BYTE) ps_d = P_OPC;
            P_OPC: begin
               opc_d = rx_byte_q;
               ps_d  = P_ARGH;
            end
            P_ARGH: begin
               argh_d = rx_byte_q;
               ps_d   = P_ARGL;
            end
            P_ARGL: begin
               argl_d = rx_byte_q;
               ps_d   = P_CSUM;
            end
            P_CSUM: begin
               ps_d = P_SYNC;
               if (rx_byte_q == (opc_q ^ argh_q ^ argl_q)) begin
                  cmd_valid_d  = 1'b1;
                  cmd_opcode_d = opc_q;
                  cmd_arg_d    = {argh_q, argl_q};
               end else begin
                  err_inc = 1'b1;
               end
            end
            default: ps_d = P_SYNC;
         endcase
      end else if (timeout) begin
         ps_d    = P_SYNC;
         err_inc = 1'b1;
      end
      err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   assign ft_rd_n    = ft_rd_n_q;
   assign rd_active  = rd_active_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_opcode = cmd_opcode_q;
   assign cmd_arg    = cmd_arg_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_ft_cmd_rx.sv
// tb/tb_ft_cmd_rx.sv - scoreboard bench for ft_cmd_rx with a behavioural FT245 FIFO model
module tb_ft_cmd_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        ft_rxf_n;
   logic [7:0]  ft_d_in = 8'hEE;
   logic        ft_rd_n;
   logic        rd_en;
   logic        rd_active;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [15:0] cmd_arg;
   logic [7:0]  err_count;

   ft_cmd_rx #(
      .RD_LOW_CYCLES (4),
      .RD_HIGH_CYCLES(4),
      .TIMEOUT_CYCLES(100),
      .SYNC_BYTE     (8'h55)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ft_rxf_n  (ft_rxf_n),
      .ft_d_in   (ft_d_in),
      .ft_rd_n   (ft_rd_n),
      .rd_en     (rd_en),
      .rd_active (rd_active),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_opcode(cmd_opcode),
      .cmd_arg   (cmd_arg),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   logic [7:0]  fifo[$];
   logic [23:0] exp_q[$];
   chk_t        chk_q[$];
   int          tests = 0;
   int          fails = 0;
   int          pulses = 0;
   int          lowcnt = 0;
   bit          in_read = 1'b0;
   bit          prev_valid = 1'b0;
   bit          prev_accept = 1'b0;
   logic [23:0] held;
   logic [23:0] got;
   chk_t        c;
   int          exp_err = 0;

   // FIFO model: data appears when RD# falls, byte is consumed when RD# rises
   always @(ft_rd_n) begin
      if (ft_rd_n === 1'b0) begin
         in_read = 1'b1;
         ft_d_in = (fifo.size() > 0) ? fifo[0] : 8'hEE;
      end else if (in_read) begin
         in_read = 1'b0;
         if (fifo.size() > 0) void'(fifo.pop_front());
         ft_d_in = 8'hEE;
      end
   end

   always @(negedge clk) ft_rxf_n = (fifo.size() == 0);

   function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", n, a, e);
      end
   endfunction

   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         cmp(c.name, c.act, c.exp);
      end
      if (rst) begin
         lowcnt      = 0;
         prev_valid  = 1'b0;
         prev_accept = 1'b0;
      end else begin
         if (ft_rd_n == 1'b0) begin
            lowcnt++;
         end else if (lowcnt != 0) begin
            pulses++;
            cmp("rd_pulse_width", lowcnt, 4);
            lowcnt = 0;
         end
         if (prev_accept && cmd_valid) cmp("valid_after_accept", 1, 0);
         if (prev_valid && !prev_accept) begin
            cmp("valid_held_until_ready", cmd_valid, 1);
            cmp("outputs_stable", {cmd_opcode, cmd_arg}, held);
            cmp("no_read_while_valid", ft_rd_n, 1);
         end
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               cmp("unexpected_cmd", {cmd_opcode, cmd_arg}, 24'h0);
            end else begin
               got = exp_q.pop_front();
               cmp("cmd_value", {cmd_opcode, cmd_arg}, got);
            end
         end
         prev_valid  = cmd_valid;
         prev_accept = cmd_valid && cmd_ready;
         held        = {cmd_opcode, cmd_arg};
      end
   end

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      chk_q.push_back('{n, a, e});
   endtask

   task automatic push_bytes(input logic [7:0] b[]);
      foreach (b[i]) fifo.push_back(b[i]);
   endtask

   task automatic wait_quiet(string n);
      int q = 0;
      int cyc = 0;
      while (q < 20 && cyc < 5000) begin
         @(posedge clk);
         cyc++;
         if (fifo.size() == 0 && !rd_active && !cmd_valid) q++;
         else q = 0;
      end
      chk(n, q, 20);
   endtask

   initial begin
      int p0;
      int cyc;
      rst       = 1'b1;
      rd_en     = 1'b1;
      cmd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ft_rd_n", ft_rd_n, 1);
      chk("reset_rd_active", rd_active, 0);
      chk("reset_cmd_valid", cmd_valid, 0);
      chk("reset_opcode_arg", {cmd_opcode, cmd_arg}, 0);
      chk("reset_err", err_count, 0);
      rst = 1'b0;

      // Basic frame
      p0 = pulses;
      exp_q.push_back(24'h01_1234);
      push_bytes('{8'h55, 8'h01, 8'h12, 8'h34, 8'h27});
      wait_quiet("t1_done");
      chk("t1_pulses", pulses - p0, 5);
      chk("t1_err", err_count, exp_err);
      chk("t1_sb_empty", exp_q.size(), 0);

      // Leading junk is discarded silently
      exp_q.push_back(24'h02_000A);
      push_bytes('{8'h00, 8'hAA, 8'h55, 8'h02, 8'h00, 8'h0A, 8'h08});
      wait_quiet("t2_done");
      chk("t2_err", err_count, exp_err);
      chk("t2_sb_empty", exp_q.size(), 0);

      // Bad checksum then good frame
      exp_q.push_back(24'h03_0001);
      push_bytes('{8'h55, 8'h03, 8'h00, 8'h01, 8'h00, 8'h55, 8'h03, 8'h00, 8'h01, 8'h02});
      exp_err++;
      wait_quiet("t3_done");
      chk("t3_err", err_count, exp_err);
      chk("t3_sb_empty", exp_q.size(), 0);

      // Mid-frame stall longer than the timeout
      push_bytes('{8'h55, 8'h04});
      wait_quiet("t4_partial");
      repeat (150) @(posedge clk);
      #1;
      exp_err++;
      chk("t4_err_timeout", err_count, exp_err);
      exp_q.push_back(24'h04_0005);
      push_bytes('{8'h55, 8'h04, 8'h00, 8'h05, 8'h01});
      wait_quiet("t4_done");
      chk("t4_err", err_count, exp_err);
      chk("t4_sb_empty", exp_q.size(), 0);

      // Consumer backpressure with a second frame queued
      cmd_ready = 1'b0;
      exp_q.push_back(24'h05_0010);
      exp_q.push_back(24'h06_ABCD);
      push_bytes('{8'h55, 8'h05, 8'h00, 8'h10, 8'h15, 8'h55, 8'h06, 8'hAB, 8'hCD, 8'h60});
      cyc = 0;
      while (!cmd_valid && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      chk("t5_first_valid", cmd_valid, 1);
      repeat (300) @(posedge clk);
      #1;
      chk("t5_second_untouched", fifo.size(), 5);
      chk("t5_rd_idle", {ft_rd_n, rd_active}, 2'b10);
      chk("t5_opcode_held", {cmd_opcode, cmd_arg}, 24'h05_0010);
      cmd_ready = 1'b1;
      wait_quiet("t5_done");
      chk("t5_err", err_count, exp_err);
      chk("t5_sb_empty", exp_q.size(), 0);

      // Asynchronous reset in the middle of the third byte read
      push_bytes('{8'h55, 8'h07, 8'h01, 8'h02, 8'h04});
      cyc = 0;
      while (!(fifo.size() == 3 && ft_rd_n == 1'b0) && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      chk("t6_reached_byte3", {fifo.size() == 3, ft_rd_n}, 2'b10);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_rd_n", ft_rd_n, 1);
      chk("t6_async_rd_active", rd_active, 0);
      chk("t6_async_valid", cmd_valid, 0);
      chk("t6_async_err", err_count, 0);
      exp_err = 0;
      fifo.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(24'h08_1234);
      push_bytes('{8'h55, 8'h08, 8'h12, 8'h34, 8'h2E});
      wait_quiet("t6_done");
      chk("t6_err", err_count, exp_err);
      chk("t6_sb_empty", exp_q.size(), 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ft_cmd_rx.md
Name: ft_cmd_rx

Overview:
- Host-to-device command receiver on the FT245-style parallel FIFO interface; the read side complementing the spectrometer's existing FT_WR upload path.
- Performs asynchronous-FIFO read cycles (FT_RXF/FT_RD), deframes 5-byte command packets and presents validated commands to the control logic (e.g. integration time, start/stop) through a valid/ready handshake.
- Sits in the top level beside the CCD/ADC uploader, clocked by clk_main; the top level owns FT_D tri-state and drives rd_en to keep this block off the bus while the uploader writes.

Parameters:
- RD_LOW_CYCLES, 4, clocks ft_rd_n is held low per byte; data sampled on the last of these (min 2).
- RD_HIGH_CYCLES, 4, clocks ft_rd_n is held high after each byte before the next read may start (min 3, covers RXF synchroniser delay).
- TIMEOUT_CYCLES, 1000000, max inter-byte gap inside a frame before the parser aborts.
- SYNC_BYTE, 8'h55, frame start marker.

Ports:
- clk  input  1  main clock (clk_main)
- rst  input  1  asynchronous active-high reset
- ft_rxf_n  input  1  FIFO has data when low; asynchronous, 2-flop synchronised internally
- ft_d_in  input  8  FT_D bus as read by the top level
- ft_rd_n  output  1  FIFO read strobe, active low
- rd_en  input  1  bus grant; no new read cycle starts while low
- rd_active  output  1  high from read start through end of precharge; top level keeps FT_D undriven and suppresses writes while high
- cmd_valid  output  1  validated command available
- cmd_ready  input  1  consumer accepts command
- cmd_opcode  output  8  command opcode
- cmd_arg  output  16  command argument, {arg_hi, arg_lo}
- err_count  output  8  saturating count of checksum errors plus timeouts

Behaviour:
- Reset (async, any time including mid-read or mid-frame): ft_rd_n=1, rd_active=0, cmd_valid=0, cmd_opcode=0, cmd_arg=0, err_count=0, synchroniser=1s, bus FSM=IDLE, parser=SYNC, counters=0.
- Frame format: SYNC_BYTE, opcode, arg_hi, arg_lo, csum; csum = opcode ^ arg_hi ^ arg_lo.
- Bus FSM:
  - IDLE -> RD_LOW when all hold in one cycle: rxf_sync==0, rd_en==1, cmd_valid==0.
  - RD_LOW: ft_rd_n=0 for exactly RD_LOW_CYCLES clocks. ft_d_in is captured on the final RD_LOW clock, and one byte_strobe is issued to the parser the next clock.
  - RD_HIGH: ft_rd_n=1 for RD_HIGH_CYCLES clocks -> IDLE.
  - rd_active=1 in RD_LOW and RD_HIGH.
  - rd_en falling mid-cycle does not abort; the cycle completes.
- Parser states: SYNC, OPC, ARGH, ARGL, CSUM.
  - SYNC: byte==SYNC_BYTE -> OPC; any other byte is discarded silently with no error.
  - OPC, ARGH, ARGL: store the byte and advance. SYNC_BYTE is ordinary data here; no resync.
  - CSUM, match: load cmd_opcode/cmd_arg, set cmd_valid=1, -> SYNC.
  - CSUM, mismatch: err_count+1, -> SYNC, cmd_valid unchanged.
- Handshake:
  - cmd_valid and the outputs hold stable until the cycle with cmd_valid&&cmd_ready; cmd_valid clears the next clock.
  - Reads are stalled while cmd_valid=1, so a command is never overwritten.
  - Latency: cmd_valid rises 1 clock after the csum byte_strobe.
- Timeout:
  - Gap counter resets on every byte_strobe and counts while parser!=SYNC.
  - Reaching TIMEOUT_CYCLES: parser -> SYNC, err_count+1.
  - Counter is held (no count) while cmd_valid=1 or rd_en=0, so stalls and bus sharing never cause timeouts.
- err_count saturates at 8'hFF. A checksum error and a timeout cannot coincide because the byte_strobe resets the counter.
- Each byte costs RD_LOW_CYCLES+RD_HIGH_CYCLES clocks minimum, plus 2-3 clocks of RXF synchroniser/IDLE overhead when the FIFO stays non-empty.

Test Plan:
- FIFO model with bytes 55 01 12 34 27, rd_en=1, cmd_ready=1: exactly 5 ft_rd_n low pulses, each 4 clocks; cmd_valid 1 clock, cmd_opcode=01, cmd_arg=1234, err_count=0.
- Bytes 00 AA 55 02 00 0A 08: first two bytes discarded silently; command opcode=02, arg=000A; err_count=0.
- Bad checksum 55 03 00 01 00, then good 55 03 00 01 02: err_count=1; only the second frame yields cmd_valid.
- TIMEOUT_CYCLES=100, feed 55 04, then idle 150 clocks, then 55 04 00 05 01: err_count=1; one command opcode=04, arg=0005.
- cmd_ready=0 with two back-to-back frames queued: after the first frame completes ft_rd_n stays high and outputs stay stable; asserting cmd_ready -> second frame is read and delivered; no timeout counted.
- Assert rst while ft_rd_n=0 in the middle of frame byte 3: ft_rd_n=1 and all outputs 0 immediately (async); a following complete frame decodes correctly.
